// File: rtl/decode_mux_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : decode_mux_arb_if
// Brief    : Channel-side and output-side handshake bundle for decode_mux_arb.
//            Perf counter signals exist only with DECODE_MUX_PERF_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
interface decode_mux_arb_if #(
  parameter int NUM_CHANNELS  = 4,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int FIFO_DEPTH    = 4,
  parameter int PERF_WIDTH    = 32
);
  localparam int CH_ID_W = $clog2(NUM_CHANNELS);
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_CHANNELS-1:0]               chValid_i;
  logic [NUM_CHANNELS*PAYLOAD_WIDTH-1:0] chPayload_i;
  logic [NUM_CHANNELS-1:0]               chReady_o;
  logic                                  outValid_o;
  logic [PAYLOAD_WIDTH-1:0]              outPayload_o;
  logic [CH_ID_W-1:0]                    outChannel_o;
  logic                                  outReady_i;
  logic [CNT_W-1:0]                      fifoCount_o;
`ifdef DECODE_MUX_PERF_EN
  logic [PERF_WIDTH-1:0]                 conflictCnt_o;
  logic [PERF_WIDTH-1:0]                 stallCnt_o;

  modport slave (
    input  chValid_i, chPayload_i, outReady_i,
    output chReady_o, outValid_o, outPayload_o, outChannel_o, fifoCount_o,
    output conflictCnt_o, stallCnt_o
  );
  modport master (
    output chValid_i, chPayload_i, outReady_i,
    input  chReady_o, outValid_o, outPayload_o, outChannel_o, fifoCount_o,
    input  conflictCnt_o, stallCnt_o
  );
`else
  modport slave (
    input  chValid_i, chPayload_i, outReady_i,
    output chReady_o, outValid_o, outPayload_o, outChannel_o, fifoCount_o
  );
  modport master (
    output chValid_i, chPayload_i, outReady_i,
    input  chReady_o, outValid_o, outPayload_o, outChannel_o, fifoCount_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/decode_mux_arb.sv
`default_nettype none
// ============================================================================
// Module   : decode_mux_arb
// Brief    : Round-robin merge of N decoder channels into one decoded stream
//            through a FIFO_DEPTH-entry output FIFO. Optional perf counters
//            are enabled by defining DECODE_MUX_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_mux_arb #(
  parameter int NUM_CHANNELS  = 4,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int FIFO_DEPTH    = 4,
  parameter int PERF_WIDTH    = 32
) (
  input  wire logic          clock_i,
  input  wire logic          resetn_i,
  input  wire logic          flush_i,
  decode_mux_arb_if.slave    bus
);
  localparam int CH_ID_W = $clog2(NUM_CHANNELS);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]   FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CH_ID_W-1:0] LAST_CH   = CH_ID_W'(NUM_CHANNELS - 1);

  logic [CNT_W-1:0]         count_q, count_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CH_ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PAYLOAD_WIDTH-1:0] mem_payload_q [FIFO_DEPTH];
  logic [PAYLOAD_WIDTH-1:0] mem_payload_d [FIFO_DEPTH];
  logic [CH_ID_W-1:0]       mem_chan_q    [FIFO_DEPTH];
  logic [CH_ID_W-1:0]       mem_chan_d    [FIFO_DEPTH];

  logic [CH_ID_W-1:0]       scan_idx [NUM_CHANNELS];
  logic [CH_ID_W-1:0]       grant_idx;
  logic                     grant_found;
  logic [NUM_CHANNELS-1:0]  ch_ready;
  logic                     out_valid;
  logic                     can_accept;
  logic                     push;
  logic                     pop;

  // Scan order starts at the round-robin pointer and wraps mod NUM_CHANNELS.
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_scan
    assign scan_idx[k] = (int'(rr_ptr_q) + k >= NUM_CHANNELS)
                       ? CH_ID_W'(int'(rr_ptr_q) + k - NUM_CHANNELS)
                       : CH_ID_W'(int'(rr_ptr_q) + k);
  end

  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (!grant_found && bus.chValid_i[scan_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[k];
      end
    end
  end

  assign out_valid  = (count_q != '0);
  assign can_accept = (count_q < FIFO_FULL) || (out_valid && bus.outReady_i);

  // Reset is folded in so no channel sees a ready while the block is held in reset.
  always_comb begin
    ch_ready = '0;
    if (grant_found && can_accept && !flush_i && resetn_i) begin
      ch_ready[grant_idx] = 1'b1;
    end
  end

  assign push = |ch_ready;
  assign pop  = out_valid && bus.outReady_i && !flush_i;

  always_comb begin
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    rr_ptr_d      = rr_ptr_q;
    mem_payload_d = mem_payload_q;
    mem_chan_d    = mem_chan_q;
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      rr_ptr_d = '0;
    end else begin
      if (push) begin
        mem_payload_d[wr_ptr_q] = bus.chPayload_i[int'(grant_idx)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
        mem_chan_d[wr_ptr_q]    = grant_idx;
        wr_ptr_d                = wr_ptr_q + 1'b1;
        rr_ptr_d                = (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      rr_ptr_q      <= '0;
      mem_payload_q <= '{default: '0};
      mem_chan_q    <= '{default: '0};
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      rr_ptr_q      <= rr_ptr_d;
      mem_payload_q <= mem_payload_d;
      mem_chan_q    <= mem_chan_d;
    end
  end

  assign bus.chReady_o    = ch_ready;
  assign bus.outValid_o   = out_valid;
  assign bus.outPayload_o = mem_payload_q[rd_ptr_q];
  assign bus.outChannel_o = mem_chan_q[rd_ptr_q];
  assign bus.fifoCount_o  = count_q;

`ifdef DECODE_MUX_PERF_EN
  logic [PERF_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;
  logic [PERF_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic                  conflict_evt;
  logic                  stall_evt;

  assign conflict_evt = ($countones(bus.chValid_i) > 1);
  assign stall_evt    = (|bus.chValid_i) && !(|ch_ready);

  // Both counters saturate rather than wrap; flush leaves them untouched.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    if (conflict_evt && (conflict_cnt_q != '1)) conflict_cnt_d = conflict_cnt_q + 1'b1;
    if (stall_evt && (stall_cnt_q != '1))       stall_cnt_d    = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      conflict_cnt_q <= '0;
      stall_cnt_q    <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign bus.conflictCnt_o = conflict_cnt_q;
  assign bus.stallCnt_o    = stall_cnt_q;
`endif
endmodule
`default_nettype wire
